// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush handling and MADD/MSUB accumulator hand-back.
// Latency 1 cycle; stall[3]/stall[4] select bubble or hold. EX_MEM_EXCEPT_EN adds exception fields.
module ex_mem_reg #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [31:0]        ex_wdata,
    input  logic [4:0]         ex_waddr,
    input  logic               ex_wr_en,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic               ex_hilo_en,
    input  logic [7:0]         ex_aluop,
    input  logic [31:0]        ex_mem_addr,
    input  logic [31:0]        ex_reg2,
    input  logic [63:0]        hilo_temp_i,
    input  logic [1:0]         cnt_i,
`ifdef EX_MEM_EXCEPT_EN
    input  logic [31:0]        ex_excepttype,
    input  logic [31:0]        ex_inst_addr,
    input  logic               ex_in_delayslot,
    output logic [31:0]        mem_excepttype,
    output logic [31:0]        mem_inst_addr,
    output logic               mem_in_delayslot,
`endif
    output logic [31:0]        mem_wdata,
    output logic [4:0]         mem_waddr,
    output logic               mem_wr_en,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic               mem_hilo_en,
    output logic [7:0]         mem_aluop,
    output logic [31:0]        mem_mem_addr,
    output logic [31:0]        mem_reg2,
    output logic [63:0]        hilo_temp_o,
    output logic [1:0]         cnt_o
);

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wr_en;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hilo_en;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
`ifdef EX_MEM_EXCEPT_EN
        logic [31:0] excepttype;
        logic [31:0] inst_addr;
        logic        in_delayslot;
`endif
    } mem_pl_t;

    mem_pl_t     pl_in;
    mem_pl_t     pl_d, pl_q;
    logic [63:0] hilo_temp_d, hilo_temp_q;
    logic [1:0]  cnt_d, cnt_q;
    logic        ex_stop, mem_stop;

    assign ex_stop  = stall[3];
    assign mem_stop = stall[4];

    always_comb begin
        pl_in          = '0;
        pl_in.wdata    = ex_wdata;
        pl_in.waddr    = ex_waddr;
        pl_in.wr_en    = ex_wr_en;
        pl_in.hi       = ex_hi;
        pl_in.lo       = ex_lo;
        pl_in.hilo_en  = ex_hilo_en;
        pl_in.aluop    = ex_aluop;
        pl_in.mem_addr = ex_mem_addr;
        pl_in.reg2     = ex_reg2;
`ifdef EX_MEM_EXCEPT_EN
        pl_in.excepttype   = ex_excepttype;
        pl_in.inst_addr    = ex_inst_addr;
        pl_in.in_delayslot = ex_in_delayslot;
`endif
    end

    // Accumulator state only survives while EX is stalled; any advance means it completed.
    always_comb begin
        pl_d        = pl_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        if (flush) begin
            pl_d        = '0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (ex_stop && !mem_stop) begin
            pl_d        = '0;
            hilo_temp_d = hilo_temp_i;
            cnt_d       = cnt_i;
        end else if (!ex_stop) begin
            pl_d        = pl_in;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else begin
            hilo_temp_d = hilo_temp_i;
            cnt_d       = cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pl_q        <= '0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            pl_q        <= pl_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wdata    = pl_q.wdata;
    assign mem_waddr    = pl_q.waddr;
    assign mem_wr_en    = pl_q.wr_en;
    assign mem_hi       = pl_q.hi;
    assign mem_lo       = pl_q.lo;
    assign mem_hilo_en  = pl_q.hilo_en;
    assign mem_aluop    = pl_q.aluop;
    assign mem_mem_addr = pl_q.mem_addr;
    assign mem_reg2     = pl_q.reg2;
    assign hilo_temp_o  = hilo_temp_q;
    assign cnt_o        = cnt_q;
`ifdef EX_MEM_EXCEPT_EN
    assign mem_excepttype   = pl_q.excepttype;
    assign mem_inst_addr    = pl_q.inst_addr;
    assign mem_in_delayslot = pl_q.in_delayslot;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, advance, bubble, hold, flush and mid-hold reset.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [4:0]  ex_waddr;
    logic        ex_wr_en, ex_hilo_en;
    logic [7:0]  ex_aluop;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [4:0]  mem_waddr;
    logic        mem_wr_en, mem_hilo_en;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_EXCEPT_EN
    logic [31:0] ex_excepttype, ex_inst_addr, mem_excepttype, mem_inst_addr;
    logic        ex_in_delayslot, mem_in_delayslot;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_wr_en(ex_wr_en),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_en(ex_hilo_en),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
`ifdef EX_MEM_EXCEPT_EN
        .ex_excepttype(ex_excepttype), .ex_inst_addr(ex_inst_addr),
        .ex_in_delayslot(ex_in_delayslot), .mem_excepttype(mem_excepttype),
        .mem_inst_addr(mem_inst_addr), .mem_in_delayslot(mem_in_delayslot),
`endif
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wr_en(mem_wr_en),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo_en(mem_hilo_en),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    // The stall controller must never stop MEM while EX runs.
    always @(posedge clk) begin
        if (rst === 1'b1)
            assert (!(stall[4] && !stall[3]))
            else $error("FAIL stall_consistency: observed stall=%b required stall[4] only with stall[3]", stall);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wdata"},    {32'h0, mem_wdata},    64'h0);
        check({tag, "_waddr"},    {59'h0, mem_waddr},    64'h0);
        check({tag, "_wr_en"},    {63'h0, mem_wr_en},    64'h0);
        check({tag, "_hi"},       {32'h0, mem_hi},       64'h0);
        check({tag, "_lo"},       {32'h0, mem_lo},       64'h0);
        check({tag, "_hilo_en"},  {63'h0, mem_hilo_en},  64'h0);
        check({tag, "_aluop"},    {56'h0, mem_aluop},    64'h0);
        check({tag, "_mem_addr"}, {32'h0, mem_mem_addr}, 64'h0);
        check({tag, "_reg2"},     {32'h0, mem_reg2},     64'h0);
        check({tag, "_hilo_tmp"}, hilo_temp_o,           64'h0);
        check({tag, "_cnt"},      {62'h0, cnt_o},        64'h0);
`ifdef EX_MEM_EXCEPT_EN
        check({tag, "_exc"},      {32'h0, mem_excepttype}, 64'h0);
        check({tag, "_iaddr"},    {32'h0, mem_inst_addr},  64'h0);
        check({tag, "_dslot"},    {63'h0, mem_in_delayslot}, 64'h0);
`endif
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b1; stall = '1;
        ex_wdata = '1; ex_waddr = '1; ex_wr_en = 1'b1; ex_hi = '1; ex_lo = '1;
        ex_hilo_en = 1'b1; ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1;
        hilo_temp_i = '1; cnt_i = '1;
`ifdef EX_MEM_EXCEPT_EN
        ex_excepttype = '1; ex_inst_addr = '1; ex_in_delayslot = 1'b1;
`endif
        #1;
        step(); step();
        check_all_zero("reset");

        // Advance: all fields loaded, accumulator cleared even with nonzero inputs
        rst = 1'b1; flush = 1'b0; stall = 6'b000000;
        ex_wdata = 32'h12345678; ex_waddr = 5'd5; ex_wr_en = 1'b1;
        ex_hi = 32'h11112222; ex_lo = 32'h33334444; ex_hilo_en = 1'b1;
        ex_aluop = 8'h23; ex_mem_addr = 32'h00001000; ex_reg2 = 32'hDEADBEEF;
        hilo_temp_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
        step();
        check("adv_wdata", {32'h0, mem_wdata}, 64'h12345678);
        check("adv_waddr", {59'h0, mem_waddr}, 64'd5);
        check("adv_wr_en", {63'h0, mem_wr_en}, 64'd1);
        check("adv_hi", {32'h0, mem_hi}, 64'h11112222);
        check("adv_lo", {32'h0, mem_lo}, 64'h33334444);
        check("adv_hilo_en", {63'h0, mem_hilo_en}, 64'd1);
        check("adv_aluop", {56'h0, mem_aluop}, 64'h23);
        check("adv_mem_addr", {32'h0, mem_mem_addr}, 64'h1000);
        check("adv_reg2", {32'h0, mem_reg2}, 64'hDEADBEEF);
        check("adv_hilo_tmp", hilo_temp_o, 64'h0);
        check("adv_cnt", {62'h0, cnt_o}, 64'h0);

        // Bubble: NOP into MEM, accumulator state passed through
        stall = 6'b001000; hilo_temp_i = 64'h00000001_FFFFFFFE; cnt_i = 2'd1;
        step();
        check("bub_wr_en", {63'h0, mem_wr_en}, 64'd0);
        check("bub_wdata", {32'h0, mem_wdata}, 64'h0);
        check("bub_waddr", {59'h0, mem_waddr}, 64'h0);
        check("bub_hilo_en", {63'h0, mem_hilo_en}, 64'd0);
        check("bub_reg2", {32'h0, mem_reg2}, 64'h0);
        check("bub_hilo_tmp", hilo_temp_o, 64'h00000001_FFFFFFFE);
        check("bub_cnt", {62'h0, cnt_o}, 64'd1);

        // Accumulate completes: advance clears cnt and loads new EX values
        stall = 6'b000000; cnt_i = 2'd2; ex_wdata = 32'hCAFEF00D; ex_waddr = 5'd7;
        step();
        check("acc_cnt", {62'h0, cnt_o}, 64'd0);
        check("acc_hilo_tmp", hilo_temp_o, 64'h0);
        check("acc_wdata", {32'h0, mem_wdata}, 64'hCAFEF00D);
        check("acc_waddr", {59'h0, mem_waddr}, 64'd7);
        check("acc_wr_en", {63'h0, mem_wr_en}, 64'd1);

        // Stall bits outside 3 and 4 have no effect
        stall = 6'b100111; ex_wdata = 32'hA5A5A5A5;
        step();
        check("ign_wdata", {32'h0, mem_wdata}, 64'hA5A5A5A5);

        // Hold for 3 cycles while EX data changes
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h0F0F0000 + i; ex_waddr = 5'd20 + 5'(i);
            hilo_temp_i = 64'h100 + 64'(i); cnt_i = 2'd1;
            step();
            check("hold_wdata", {32'h0, mem_wdata}, 64'hA5A5A5A5);
            check("hold_waddr", {59'h0, mem_waddr}, 64'd7);
            check("hold_hilo_tmp", hilo_temp_o, 64'h100 + 64'(i));
            check("hold_cnt", {62'h0, cnt_o}, 64'd1);
        end

        // Flush beats stall
        flush = 1'b1; stall = 6'b011000;
        ex_wdata = 32'h77777777; ex_wr_en = 1'b1; ex_hilo_en = 1'b1; cnt_i = 2'd2;
        step();
        check_all_zero("flush");

        // Reset during Hold with cnt_o=1
        flush = 1'b0; stall = 6'b000000; ex_wdata = 32'h55AA55AA;
        step();
        check("pre_wdata", {32'h0, mem_wdata}, 64'h55AA55AA);
        stall = 6'b011000; cnt_i = 2'd1; hilo_temp_i = 64'h1234;
        step();
        check("pre_cnt", {62'h0, cnt_o}, 64'd1);
        check("pre_hold_wdata", {32'h0, mem_wdata}, 64'h55AA55AA);
        rst = 1'b0;
        step();
        check_all_zero("midrst");
        rst = 1'b1; stall = 6'b000000; ex_wdata = 32'h0BADCAFE; ex_waddr = 5'd31;
        step();
        check("resume_wdata", {32'h0, mem_wdata}, 64'h0BADCAFE);
        check("resume_waddr", {59'h0, mem_waddr}, 64'd31);
        check("resume_wr_en", {63'h0, mem_wr_en}, 64'd1);
        check("resume_cnt", {62'h0, cnt_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures the EX results each cycle: GPR writeback, HI/LO writeback, and load/store info.
- Applies the global stall vector and flush.
- Holds the two-cycle accumulator state (hilo_temp and cnt) for MADD/MADDU/MSUB/MSUBU while EX is stalled, and hands it back to EX.

Parameters:
- STALL_W, 6, width of the global stall vector. Bit 3 is the EX stage; bit 4 is the MEM stage.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge of clk resets the block
- stall  in  STALL_W  per-stage stop request; 1 = stop
- flush  in  1  pipeline flush; clears all outputs
- ex_wdata  in  32  GPR write data from EX
- ex_waddr  in  5  GPR write address
- ex_wr_en  in  1  GPR write enable
- ex_hi  in  32  HI write value
- ex_lo  in  32  LO write value
- ex_hilo_en  in  1  HI/LO write enable
- ex_aluop  in  8  ALU op code, forwarded to MEM for load/store decode
- ex_mem_addr  in  32  effective load/store address
- ex_reg2  in  32  store data
- hilo_temp_i  in  64  partial accumulator product from EX
- cnt_i  in  2  accumulator cycle count from EX
- mem_wdata  out  32  registered ex_wdata
- mem_waddr  out  5  registered ex_waddr
- mem_wr_en  out  1  registered ex_wr_en
- mem_hi  out  32  registered ex_hi
- mem_lo  out  32  registered ex_lo
- mem_hilo_en  out  1  registered ex_hilo_en
- mem_aluop  out  8  registered ex_aluop
- mem_mem_addr  out  32  registered ex_mem_addr
- mem_reg2  out  32  registered ex_reg2
- hilo_temp_o  out  64  accumulator state returned to EX
- cnt_o  out  2  count returned to EX

Behaviour:
- Outputs are registered only; there is no combinational path from input to output. Latency is 1 cycle.
- Priority order at each rising clk edge is: reset, then flush, then bubble, then advance, then hold.
- Reset (rst==0):
  - All outputs go to 0.
  - mem_wr_en=0 and mem_hilo_en=0.
  - hilo_temp_o=0 and cnt_o=0.
- Flush (flush==1, rst==1):
  - All pipeline outputs go to 0.
  - hilo_temp_o=0 and cnt_o=0.
  - Flush overrides any stall value.
- Bubble (stall[3]==1 and stall[4]==0):
  - EX is stopped and MEM runs, so a NOP is inserted.
  - All mem_* outputs go to 0.
  - hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so the multi-cycle accumulate continues.
- Advance (stall[3]==0):
  - All mem_* outputs are loaded from the ex_* inputs.
  - hilo_temp_o=0 and cnt_o=0; the accumulate has completed.
- Hold (stall[3]==1 and stall[4]==1):
  - All mem_* outputs keep their values.
  - hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i.
- Inconsistent stall (stall[4]==1 with stall[3]==0): handled as Advance. The controller never issues this, and the bench flags it with an assertion.
- Write-enable bits are never X after reset; during bubble and flush they are forced to 0.
- Stall bits other than 3 and 4 are ignored.

Optional Feature:
- Macro: EX_MEM_EXCEPT_EN.
- When defined, the block adds these ports:
  - ex_excepttype  in  32
  - ex_inst_addr  in  32
  - ex_in_delayslot  in  1
  - mem_excepttype  out  32
  - mem_inst_addr  out  32
  - mem_in_delayslot  out  1
- These fields follow the same reset/flush/bubble/advance/hold rules; they are zero on reset, flush and bubble.
- When not defined, the ports are absent and there is no exception logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all inputs at 0xFFFFFFFF -> every output is 0 and cnt_o=0.
- Advance: rst=1, stall=0, ex_wdata=0x12345678, ex_waddr=5, ex_wr_en=1 -> next cycle mem_wdata=0x12345678, mem_waddr=5, mem_wr_en=1.
- Bubble: stall=6'b001000, hilo_temp_i=0x00000001_FFFFFFFE, cnt_i=1 -> next cycle mem_wr_en=0, mem_wdata=0, hilo_temp_o=0x00000001_FFFFFFFE, cnt_o=1. Then stall=0, cnt_i=2 -> next cycle cnt_o=0 and mem_* take the new EX values.
- Hold: load mem_wdata=0xA5A5A5A5, then stall=6'b011000 for 3 cycles with changing ex_wdata -> mem_wdata stays 0xA5A5A5A5 throughout.
- Flush: flush=1 together with stall=6'b011000 and valid EX data -> next cycle all outputs are 0, mem_hilo_en=0, cnt_o=0.
- Reset mid-operation: during Hold with cnt_o=1, drive rst=0 for 1 cycle -> all outputs 0. Then with rst=1 and stall=0, normal Advance resumes on the next cycle.
